// File: rtl/ccc_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ccc_lock_sequencer
//  Description : Waits for every PLL/CCC lock to stay stable for a filter
//                window, then releases per-channel resets in order and
//                supervises the locks afterwards.
//  Revision    : 1.0 - initial release
// ============================================================================
module ccc_lock_sequencer #(
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CYCLES = 1024,
  parameter int SEQ_GAP     = 16
) (
  input  logic              REF_CLK_0,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] PLL_LOCK,
  input  logic              CLR_LOSS,
  output logic [NUM_CH-1:0] RST_OUT,
  output logic              READY,
  output logic              LOCK_LOST,
  output logic [7:0]        LOSS_CNT,
  output logic [2:0]        STATE
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FILTER  = 3'd1;
  localparam logic [2:0] S_RELEASE = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_FAULT   = 3'd4;

  localparam logic [15:0]       FILT_LAST = 16'(LOCK_CYCLES - 1);
  localparam logic [7:0]        GAP_LAST  = 8'(SEQ_GAP - 1);
  localparam logic [CH_W-1:0]   IDX_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] CH_ONE    = NUM_CH'(1);
  localparam logic [NUM_CH-1:0] CH_ALL    = {NUM_CH{1'b1}};

  logic [NUM_CH-1:0] lock_s;
  logic              all_locked;
  logic              loss_event;

  logic [2:0]        state_q, state_d;
  logic [15:0]       filt_cnt_q, filt_cnt_d;
  logic [7:0]        gap_cnt_q, gap_cnt_d;
  logic [CH_W-1:0]   idx_q, idx_d;
  logic [NUM_CH-1:0] rst_out_q, rst_out_d;
  logic              ready_q, ready_d;
  logic              lock_lost_q, lock_lost_d;
  logic [7:0]        loss_cnt_q, loss_cnt_d;

  // One independent synchroniser per lock input; the FSM only sees lock_s.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], PLL_LOCK[i]};
    end

    always_ff @(posedge REF_CLK_0 or posedge RESET) begin
      if (RESET) begin
        sync_q <= '0;
      end else begin
        sync_q <= sync_d;
      end
    end

    assign lock_s[i] = sync_q[SYNC_STAGES-1];
  end

  assign all_locked = &lock_s;
  assign loss_event = ((state_q == S_RELEASE) || (state_q == S_RUN)) && !all_locked;

  // State register
  always_ff @(posedge REF_CLK_0 or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (all_locked) begin
          state_d = S_FILTER;
        end
      end
      S_FILTER: begin
        if (!all_locked) begin
          state_d = S_IDLE;
        end else if (filt_cnt_q == FILT_LAST) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!all_locked) begin
          state_d = S_FAULT;
        end else if (idx_q == IDX_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!all_locked) begin
          state_d = S_FAULT;
        end
      end
      S_FAULT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output / datapath logic: counters and outputs are registered, so the
  // reset pattern changes on the same edge as the state transition.
  always_comb begin
    filt_cnt_d = '0;
    gap_cnt_d  = '0;
    idx_d      = '0;
    rst_out_d  = CH_ALL;
    ready_d    = 1'b0;

    case (state_q)
      S_FILTER: begin
        if (state_d == S_RELEASE) begin
          rst_out_d = CH_ALL & ~CH_ONE;
        end else if (state_d == S_FILTER) begin
          filt_cnt_d = filt_cnt_q + 16'd1;
        end
      end
      S_RELEASE: begin
        if (state_d == S_RUN) begin
          rst_out_d = '0;
          ready_d   = 1'b1;
        end else if (state_d == S_RELEASE) begin
          if (gap_cnt_q == GAP_LAST) begin
            idx_d     = idx_q + 1'b1;
            rst_out_d = rst_out_q & ~(CH_ONE << (idx_q + 1'b1));
          end else begin
            idx_d     = idx_q;
            gap_cnt_d = gap_cnt_q + 8'd1;
            rst_out_d = rst_out_q;
          end
        end
      end
      S_RUN: begin
        if (state_d == S_RUN) begin
          rst_out_d = '0;
          ready_d   = 1'b1;
        end
      end
      default: begin
        rst_out_d = CH_ALL;
      end
    endcase

    // A loss in the same cycle as a clear wins and counts as the first event.
    if (loss_event) begin
      lock_lost_d = 1'b1;
      if (CLR_LOSS) begin
        loss_cnt_d = 8'd1;
      end else if (loss_cnt_q == 8'hFF) begin
        loss_cnt_d = loss_cnt_q;
      end else begin
        loss_cnt_d = loss_cnt_q + 8'd1;
      end
    end else if (CLR_LOSS) begin
      lock_lost_d = 1'b0;
      loss_cnt_d  = '0;
    end else begin
      lock_lost_d = lock_lost_q;
      loss_cnt_d  = loss_cnt_q;
    end
  end

  always_ff @(posedge REF_CLK_0 or posedge RESET) begin
    if (RESET) begin
      filt_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      idx_q       <= '0;
      rst_out_q   <= CH_ALL;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      loss_cnt_q  <= '0;
    end else begin
      filt_cnt_q  <= filt_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      idx_q       <= idx_d;
      rst_out_q   <= rst_out_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  assign RST_OUT   = rst_out_q;
  assign READY     = ready_q;
  assign LOCK_LOST = lock_lost_q;
  assign LOSS_CNT  = loss_cnt_q;
  assign STATE     = state_q;

endmodule
`default_nettype wire
